// File: rtl/lab3_mem_line_mem_responder.sv
// Line-wide memory responder for the 16B cache<->memory interface.
// Serves one request at a time. The response appears p_latency cycles after the request is accepted.
// Optional feature macro: LAB3_MEM_LINE_MEM_RESPONDER_STATS_EN (adds num_reads / num_writes).
//
// memreq_msg  [176:0]: {rsvd[1:0], type_[2:0], opaque[7:0], addr[31:0], len[3:0], data[127:0]}
// memresp_msg [144:0]: {type_[2:0], opaque[7:0], test[1:0], len[3:0], data[127:0]}
// The two reserved request MSBs are ignored.
module lab3_mem_line_mem_responder #(
    parameter int unsigned p_num_lines = 256,
    parameter int unsigned p_latency   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memreq_val,
    output logic         memreq_rdy,
    input  logic [176:0] memreq_msg,
    output logic         memresp_val,
    input  logic         memresp_rdy,
    output logic [144:0] memresp_msg
`ifdef LAB3_MEM_LINE_MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]  num_reads,
    output logic [31:0]  num_writes
`endif
);

    localparam int unsigned IdxW = $clog2(p_num_lines);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic [2:0]      req_type;
    logic [7:0]      req_opaque;
    logic [31:0]     req_addr;
    logic [3:0]      req_len;
    logic [127:0]    req_data;
    logic [IdxW-1:0] idx;
    logic            accept;
    logic            is_read;
    logic            is_write;
    logic [15:0]     byte_en;

    logic [127:0] mem [p_num_lines];

    assign req_type   = memreq_msg[174:172];
    assign req_opaque = memreq_msg[171:164];
    assign req_addr   = memreq_msg[163:132];
    assign req_len    = memreq_msg[131:128];
    assign req_data   = memreq_msg[127:0];
    assign idx        = req_addr[4 +: IdxW];

    // Upper address bits alias onto the same lines; reserved bits carry nothing.
    logic unused_bits;
    assign unused_bits = ^{memreq_msg[176:175], req_addr[31:4+IdxW]};

    assign is_read  = (req_type == 3'd0);
    assign is_write = (req_type == 3'd1) || (req_type == 3'd2);

    // Gate with reset so the port is low while reset is held, and high as soon as it is released.
    assign memreq_rdy  = reset && (state_q == StIdle);
    assign accept      = memreq_val && memreq_rdy;
    assign memresp_val = (state_q == StResp);

    // Byte enables: len==0 means the whole line; otherwise a window clipped at byte 15.
    always_comb begin
        logic [4:0] lo;
        logic [4:0] hi;
        byte_en = '0;
        lo      = {1'b0, req_addr[3:0]};
        hi      = lo + {1'b0, req_len};
        for (int i = 0; i < 16; i++) begin
            byte_en[i] = (req_len == 4'd0) || ((5'(i) >= lo) && (5'(i) < hi));
        end
    end

    // FSM next state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (p_latency > 0) begin
                        state_d = StWait;
                        cnt_d   = 8'(p_latency - 1);
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 8'd0) state_d = StResp;
                else               cnt_d   = cnt_q - 8'd1;
            end
            StResp: begin
                if (memresp_rdy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Response message is captured at accept, with the read line sampled before any write lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memresp_msg <= '0;
        end else if (accept) begin
            memresp_msg <= {req_type, req_opaque, 2'b00, req_len,
                            is_read ? mem[idx] : 128'd0};
        end
    end

    // Line array write. It has no reset, so contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && is_write) begin
            for (int i = 0; i < 16; i++) begin
                if (byte_en[i]) mem[idx][8*i +: 8] <= req_data[8*i +: 8];
            end
        end
    end

`ifdef LAB3_MEM_LINE_MEM_RESPONDER_STATS_EN
    // Accept counters. They wrap naturally at 32 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_reads  <= 32'd0;
            num_writes <= 32'd0;
        end else if (accept) begin
            if (is_read)  num_reads  <= num_reads + 32'd1;
            if (is_write) num_writes <= num_writes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lab3_mem_line_mem_responder.sv
// Directed bench for lab3_mem_line_mem_responder with a response scoreboard.
// Instance dut uses latency 2. Instance dut0 uses latency 0.
module tb_lab3_mem_line_mem_responder;

    localparam int Lat = 2;
    localparam logic [127:0] D1 = 128'h0F0E0D0C0B0A09080706050403020100;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         memreq_val = 1'b0;
    logic         memreq_rdy;
    logic [176:0] memreq_msg = '0;
    logic         memresp_val;
    logic         memresp_rdy = 1'b0;
    logic [144:0] memresp_msg;
    logic         z_memreq_val = 1'b0;
    logic         z_memreq_rdy;
    logic [176:0] z_memreq_msg = '0;
    logic         z_memresp_val;
    logic         z_memresp_rdy = 1'b0;
    logic [144:0] z_memresp_msg;
`ifdef LAB3_MEM_LINE_MEM_RESPONDER_STATS_EN
    logic [31:0]  num_reads, num_writes, z_num_reads, z_num_writes;
`endif

    int checks = 0;
    int failures = 0;
    logic [144:0] sb [$];

    always #5 clk = ~clk;

    lab3_mem_line_mem_responder #(.p_num_lines(256), .p_latency(Lat)) dut (
        .clk(clk), .reset(reset),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg)
`ifdef LAB3_MEM_LINE_MEM_RESPONDER_STATS_EN
        , .num_reads(num_reads), .num_writes(num_writes)
`endif
    );

    lab3_mem_line_mem_responder #(.p_num_lines(256), .p_latency(0)) dut0 (
        .clk(clk), .reset(reset),
        .memreq_val(z_memreq_val), .memreq_rdy(z_memreq_rdy), .memreq_msg(z_memreq_msg),
        .memresp_val(z_memresp_val), .memresp_rdy(z_memresp_rdy), .memresp_msg(z_memresp_msg)
`ifdef LAB3_MEM_LINE_MEM_RESPONDER_STATS_EN
        , .num_reads(z_num_reads), .num_writes(z_num_writes)
`endif
    );

    task automatic chk(input string tag, input logic [144:0] obs, input logic [144:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request and pushes the expected response.
    // Measures latency, holds memresp_rdy low for 'hold' cycles, then fires the response.
    task automatic do_req(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                          input logic [3:0] l, input logic [127:0] d,
                          input logic [127:0] exp_data, input int hold);
        int n;
        int lat;
        logic [144:0] snap;
        sb.push_back({t, op, 2'b00, l, exp_data});
        @(negedge clk);
        memreq_val = 1'b1;
        memreq_msg = {2'b00, t, op, a, l, d};
        n = 0;
        while (!memreq_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_rdy", memreq_rdy, 1);
        @(posedge clk);
        #1;
        memreq_val = 1'b0;
        memreq_msg = '0;
        lat = 0;
        while (!memresp_val && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, Lat);
        chk("req_rdy_low_in_resp", memreq_rdy, 0);
        snap = memresp_msg;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_val", memresp_val, 1);
            chk("hold_msg", memresp_msg, snap);
            chk("hold_req_rdy", memreq_rdy, 0);
        end
        chk("resp_msg", memresp_msg, sb.pop_front());
        memresp_rdy = 1'b1;
        @(posedge clk);
        #1;
        memresp_rdy = 1'b0;
        chk("val_after_fire", memresp_val, 0);
        chk("req_rdy_after_fire", memreq_rdy, 1);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_req_rdy", memreq_rdy, 0);
        chk("rst_resp_val", memresp_val, 0);
        chk("rst_resp_msg", memresp_msg, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rdy_after_rst", memreq_rdy, 1);

        // WRITE_INIT followed by a read of the same line
        do_req(3'd2, 8'h11, 32'h0000_0010, 4'd0, D1, 128'd0, 0);
        do_req(3'd0, 8'h5A, 32'h0000_0010, 4'd0, '0, D1, 0);

        // Partial write into a zeroed line
        do_req(3'd2, 8'h12, 32'h0000_0000, 4'd0, 128'd0, 128'd0, 0);
        do_req(3'd1, 8'h13, 32'h0000_0008, 4'd4, {16{8'hDD}}, 128'd0, 0);
        do_req(3'd0, 8'h14, 32'h0000_0000, 4'd0, '0,
               128'h0000_0000_DDDD_DDDD_0000_0000_0000_0000, 0);

        // Write window runs past byte 15 and is clipped, leaving the next line untouched
        do_req(3'd1, 8'h15, 32'h0000_000E, 4'd4, {16{8'hEE}}, 128'd0, 0);
        do_req(3'd0, 8'h16, 32'h0000_0003, 4'd7, '0,
               128'hEEEE_0000_DDDD_DDDD_0000_0000_0000_0000, 0);
        do_req(3'd0, 8'h17, 32'h0000_0010, 4'd0, '0, D1, 0);

        // Backpressure: memresp_rdy held low for five cycles in RESP
        do_req(3'd0, 8'hA5, 32'h0000_0010, 4'd0, '0, D1, 5);

        // Unknown type echoes the request fields with zero data
        do_req(3'd5, 8'h77, 32'h0000_0010, 4'd3, {16{8'hFF}}, 128'd0, 0);
        do_req(3'd0, 8'h18, 32'h0000_0010, 4'd0, '0, D1, 0);

        // Address bits above the line index alias onto the same line
        do_req(3'd0, 8'h19, 32'hABCD_F01F, 4'd0, '0, D1, 0);

        // Latency 0 instance: response is valid right after the accept edge
        @(negedge clk);
        z_memreq_val = 1'b1;
        z_memreq_msg = {2'b00, 3'd3, 8'h33, 32'h0, 4'd9, 128'd0};
        @(posedge clk);
        #1;
        z_memreq_val = 1'b0;
        chk("lat0_val", z_memresp_val, 1);
        chk("lat0_msg", z_memresp_msg, {3'd3, 8'h33, 2'b00, 4'd9, 128'd0});
        z_memresp_rdy = 1'b1;
        @(posedge clk);
        #1;
        z_memresp_rdy = 1'b0;
        chk("lat0_done", z_memresp_val, 0);

        // Reset asserted while the request is in WAIT: the response is dropped
        @(negedge clk);
        memreq_val = 1'b1;
        memreq_msg = {2'b00, 3'd0, 8'h99, 32'h10, 4'd0, 128'd0};
        @(posedge clk);
        #1;
        memreq_val = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_val", memresp_val, 0);
        chk("midrst_req_rdy", memreq_rdy, 0);
        chk("midrst_msg", memresp_msg, 0);
`ifdef LAB3_MEM_LINE_MEM_RESPONDER_STATS_EN
        chk("midrst_reads", num_reads, 0);
        chk("midrst_writes", num_writes, 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_rdy", memreq_rdy, 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("dropped_resp_val", memresp_val, 0);
        end

        // Array contents survive reset
        do_req(3'd0, 8'h20, 32'h0000_0010, 4'd0, '0, D1, 0);
`ifdef LAB3_MEM_LINE_MEM_RESPONDER_STATS_EN
        chk("stats_reads", num_reads, 1);
`endif
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
